// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU control FSM: state encoding, instruction
// field codes, memory-command / PC-source / register-select / writeback-source
// encodings, the decoded instruction class and the decoder function that maps
// opcode/op onto that class.
//
// Configuration macro: CTRL_BRANCH_LINK_EN
//   defined   -> opcode 010 decodes BL (op 11), BX (op 00) and BLX (op 10)
//   undefined -> opcode 010 is treated as an illegal instruction (HALT)
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam int STATE_W = 5;

  // S_LINK and S_BX_PC are reachable only with CTRL_BRANCH_LINK_EN.
  typedef enum logic [STATE_W-1:0] {
    S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
    S_GET_A, S_GET_B, S_EXEC, S_WR_REG,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB,
    S_STR_GETB, S_STR_C, S_MEM_WR,
    S_BRANCH, S_HALT,
    S_LINK, S_BX_PC
  } state_t;

  // opcode field IR[15:13]
  localparam logic [2:0] OPC_BRANCH = 3'b001;
  localparam logic [2:0] OPC_BLINK  = 3'b010;
  localparam logic [2:0] OPC_LDR    = 3'b011;
  localparam logic [2:0] OPC_STR    = 3'b100;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_HALT   = 3'b111;

  // op field IR[12:11]
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_BX      = 2'b00;
  localparam logic [1:0] OP_BLX     = 2'b10;
  localparam logic [1:0] OP_BL      = 2'b11;

  // cond field IR[10:8]
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  localparam logic [1:0] PC_INC  = 2'b00;  // PC + 1
  localparam logic [1:0] PC_REL  = 2'b01;  // PC + 1 + sximm8
  localparam logic [1:0] PC_ZERO = 2'b10;
  localparam logic [1:0] PC_DOUT = 2'b11;  // datapath_out (C)

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RN   = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  typedef enum logic [3:0] {
    CLS_HALT, CLS_MOV_IMM, CLS_MOV_REG, CLS_ALU, CLS_CMP,
    CLS_LDR, CLS_STR, CLS_BRANCH, CLS_BL, CLS_BX, CLS_BLX
  } instr_cls_t;

  // Anything not explicitly recognised decodes to CLS_HALT.
  function automatic instr_cls_t decode_instr(input logic [2:0] opc,
                                              input logic [1:0] opf);
    instr_cls_t cls;
    cls = CLS_HALT;
    case (opc)
      OPC_MOV: begin
        if (opf == OP_MOV_IMM)      cls = CLS_MOV_IMM;
        else if (opf == OP_MOV_REG) cls = CLS_MOV_REG;
      end
      OPC_ALU:    cls = (opf == OP_CMP) ? CLS_CMP : CLS_ALU;
      OPC_LDR:    cls = CLS_LDR;
      OPC_STR:    cls = CLS_STR;
      OPC_BRANCH: cls = CLS_BRANCH;
`ifdef CTRL_BRANCH_LINK_EN
      OPC_BLINK: begin
        case (opf)
          OP_BL:   cls = CLS_BL;
          OP_BX:   cls = CLS_BX;
          OP_BLX:  cls = CLS_BLX;
          default: cls = CLS_HALT;
        endcase
      end
`endif
      default:    cls = CLS_HALT;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Combinational branch-condition evaluator.
//   cond   [2:0] : branch condition code (IR[10:8])
//   status [2:0] : datapath flags {V, N, Z}
//   taken        : 1 when the branch should be taken
// Codes 101..111 are never taken.
// -----------------------------------------------------------------------------
module branch_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] status,
  output logic       taken
);

  logic z, n, v, lt;

  assign z  = status[0];
  assign n  = status[1];
  assign v  = status[2];
  assign lt = n ^ v;  // signed less-than after a CMP

  always_comb begin
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_LT: taken = lt;
      COND_LE: taken = z | lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Moore controller that fetches, decodes and sequences every CPU instruction.
// All outputs are decoded from registered state: the instruction class and the
// branch decision are captured when leaving DECODE, so no output depends
// combinationally on opcode/op/cond/status.
//
// Ports
//   clk, reset (async, active-high)
//   opcode[2:0], op[1:0], cond[2:0] : instruction register fields
//   status[2:0]                     : datapath flags {V, N, Z}
//   load_ir, load_pc, pc_src[1:0], addr_sel, load_addr, mem_cmd[1:0]
//   nsel[2:0], vsel[1:0], write, loada, loadb, loadc, loads, asel, bsel
//   halted                          : high while in HALT
//
// Configuration macro: CTRL_BRANCH_LINK_EN enables BL / BX / BLX (opcode 010).
// -----------------------------------------------------------------------------
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int NSTATE_W = 5,
  parameter int PC_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic [2:0] status,
  output logic       load_ir,
  output logic       load_pc,
  output logic [1:0] pc_src,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       halted
);

  if (NSTATE_W < $bits(state_t) || PC_W < 1) begin : g_param_check
    $error("cpu_control_fsm: NSTATE_W too small for the state encoding");
  end

  state_t     state, next_state;
  instr_cls_t cls;       // class of the instruction in flight
  instr_cls_t dec_cls;
  logic       br_taken;  // branch decision captured in DECODE
  logic       taken;

  assign dec_cls = decode_instr(opcode, op);

  branch_cond_eval u_cond (
    .cond   (cond),
    .status (status),
    .taken  (taken)
  );

  // Flags only change on loads (end of a CMP's EXEC), so sampling them in
  // DECODE gives the same answer as sampling in BRANCH.
  // NOTE: non-blocking assignments keep every register updating from the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RST;
      cls      <= CLS_HALT;
      br_taken <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        cls      <= dec_cls;
        br_taken <= taken || (dec_cls == CLS_BL);
      end
    end
  end

  // NOTE: every output and next_state gets a default before the case, so no
  // path through the block leaves a signal unassigned (no inferred latches).
  always_comb begin
    next_state = state;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    pc_src     = PC_INC;
    addr_sel   = 1'b0;
    load_addr  = 1'b0;
    mem_cmd    = MEM_NONE;
    nsel       = NSEL_NONE;
    vsel       = VSEL_C;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    halted     = 1'b0;

    case (state)
      S_RST: begin
        load_pc    = 1'b1;
        pc_src     = PC_ZERO;
        next_state = S_IF1;
      end
      S_IF1: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        next_state = S_IF2;
      end
      S_IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        load_ir    = 1'b1;
        next_state = S_UPD_PC;
      end
      S_UPD_PC: begin
        load_pc    = 1'b1;
        pc_src     = PC_INC;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        case (dec_cls)
          CLS_MOV_IMM:                      next_state = S_WR_REG;
          CLS_MOV_REG, CLS_BX:              next_state = S_GET_B;
          CLS_ALU, CLS_CMP, CLS_LDR, CLS_STR: next_state = S_GET_A;
          CLS_BRANCH:                       next_state = S_BRANCH;
          CLS_BL, CLS_BLX:                  next_state = S_LINK;
          default:                          next_state = S_HALT;
        endcase
      end
      S_GET_A: begin
        nsel       = NSEL_RN;
        loada      = 1'b1;
        next_state = (cls == CLS_LDR || cls == CLS_STR) ? S_MEM_ADDR : S_GET_B;
      end
      S_GET_B: begin
        // BX/BLX take their target from Rd; everything else reads Rm.
        nsel       = (cls == CLS_BX || cls == CLS_BLX) ? NSEL_RD : NSEL_RM;
        loadb      = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        loadc = 1'b1;
        // Moves (and BX targets) pass B through with the A operand zeroed.
        asel  = (cls == CLS_MOV_REG || cls == CLS_BX || cls == CLS_BLX);
        loads = (cls == CLS_CMP);
        if (cls == CLS_CMP)                        next_state = S_IF1;
        else if (cls == CLS_BX || cls == CLS_BLX)  next_state = S_BX_PC;
        else                                       next_state = S_WR_REG;
      end
      S_WR_REG: begin
        write = 1'b1;
        if (cls == CLS_MOV_IMM) begin
          nsel = NSEL_RN;
          vsel = VSEL_IMM;
        end else begin
          nsel = NSEL_RD;
          vsel = VSEL_C;
        end
        next_state = S_IF1;
      end
      S_MEM_ADDR: begin
        bsel       = 1'b1;  // A + sximm5
        loadc      = 1'b1;
        next_state = (cls == CLS_LDR) ? S_MEM_RD : S_STR_GETB;
      end
      // The address computed in MEM_ADDR sits in C; it is captured into the
      // data-address register during the following cycle (MEM_RD / STR_GETB),
      // and the memory sees it from MEM_WB / MEM_WR onwards.
      S_MEM_RD: begin
        mem_cmd    = MEM_READ;
        load_addr  = 1'b1;
        next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_cmd    = MEM_READ;
        nsel       = NSEL_RD;
        vsel       = VSEL_MDATA;
        write      = 1'b1;
        next_state = S_IF1;
      end
      S_STR_GETB: begin
        nsel       = NSEL_RD;
        loadb      = 1'b1;
        load_addr  = 1'b1;
        next_state = S_STR_C;
      end
      S_STR_C: begin
        asel       = 1'b1;
        loadc      = 1'b1;
        next_state = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd    = MEM_WRITE;
        next_state = S_IF1;
      end
      S_BRANCH: begin
        if (br_taken) begin
          load_pc = 1'b1;
          pc_src  = PC_REL;
        end
        next_state = S_IF1;
      end
`ifdef CTRL_BRANCH_LINK_EN
      S_LINK: begin
        // The datapath decoder forces Rn to R7 for link writes.
        nsel       = NSEL_RN;
        vsel       = VSEL_PC;
        write      = 1'b1;
        next_state = (cls == CLS_BL) ? S_BRANCH : S_GET_B;
      end
      S_BX_PC: begin
        load_pc    = 1'b1;
        pc_src     = PC_DOUT;
        next_state = S_IF1;
      end
`endif
      S_HALT: begin
        halted = 1'b1;
      end
      default: next_state = S_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_fsm
// Self-checking bench for cpu_control_fsm. Each instruction is run from one
// IF1 cycle to the next and summarised (cycle count, register writes, memory
// reads/writes, PC updates, flag loads); that summary is compared with a
// per-instruction reference derived from the instruction-set rules.
// -----------------------------------------------------------------------------
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [2:0] cond = 3'b000;
  logic [2:0] status = 3'b000;
  logic       load_ir, load_pc, addr_sel, load_addr, write;
  logic       loada, loadb, loadc, loads, asel, bsel, halted;
  logic [1:0] pc_src, mem_cmd, vsel;
  logic [2:0] nsel;

  cpu_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .status(status), .load_ir(load_ir), .load_pc(load_pc), .pc_src(pc_src),
    .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
    .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [20:0] ctl;
  assign ctl = {load_ir, load_pc, pc_src, addr_sel, load_addr, mem_cmd, nsel,
                vsel, write, loada, loadb, loadc, loads, asel, bsel, halted};

  localparam logic [20:0] RST_CTL  = {1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00,
                                      3'b000, 2'b00, 1'b0, 7'b0};
  localparam logic [20:0] IF1_CTL  = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01,
                                      3'b000, 2'b00, 1'b0, 7'b0};
  localparam logic [20:0] HALT_CTL = 21'd1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] oc;
    logic [1:0] op;
    logic [2:0] cd;
    logic [2:0] st;
  } instr_t;

  typedef struct packed {
    logic [7:0] cycles;
    logic [3:0] writes;
    logic [2:0] wr_nsel;
    logic [1:0] wr_vsel;
    logic [3:0] mem_wr;
    logic [3:0] data_rd;
    logic [3:0] pc_rel;
    logic [3:0] pc_inc;
    logic [3:0] loads;
    logic [3:0] load_addr;
    logic [3:0] load_ir;
    logic       halted;
  } stats_t;

  function automatic instr_t mk(input logic [2:0] oc, input logic [1:0] o,
                                input logic [2:0] cd, input logic [2:0] st);
    instr_t i;
    i.oc = oc; i.op = o; i.cd = cd; i.st = st;
    return i;
  endfunction

  // Branch rule: flags are {V, N, Z}; "less than" means N differs from V.
  function automatic bit ref_taken(input logic [2:0] cd, input logic [2:0] st);
    bit z, lt;
    z  = st[0];
    lt = (st[1] != st[2]);
    case (cd)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return lt;
      3'd4:    return z || lt;
      default: return 1'b0;
    endcase
  endfunction

  // Expected per-instruction summary. Every instruction does one IR load and
  // one PC increment; illegal encodings stop after 4 cycles in HALT.
  function automatic stats_t model(input instr_t i);
    stats_t e;
    e = '0;
    e.load_ir = 1;
    e.pc_inc  = 1;
    e.cycles  = 4;
    e.halted  = 1'b1;
    if (i.oc == 3'b110 && i.op == 2'b10) begin          // MOV Rn,#imm
      e.halted = 0; e.cycles = 5; e.writes = 1; e.wr_nsel = 3'b100; e.wr_vsel = 2'b10;
    end else if (i.oc == 3'b110 && i.op == 2'b00) begin // MOV Rd,Rm
      e.halted = 0; e.cycles = 7; e.writes = 1; e.wr_nsel = 3'b010; e.wr_vsel = 2'b00;
    end else if (i.oc == 3'b101 && i.op == 2'b01) begin // CMP
      e.halted = 0; e.cycles = 7; e.loads = 1;
    end else if (i.oc == 3'b101) begin                  // ADD/AND/MVN
      e.halted = 0; e.cycles = 8; e.writes = 1; e.wr_nsel = 3'b010; e.wr_vsel = 2'b00;
    end else if (i.oc == 3'b011) begin                  // LDR
      e.halted = 0; e.cycles = 8; e.writes = 1; e.wr_nsel = 3'b010; e.wr_vsel = 2'b11;
      e.data_rd = 2; e.load_addr = 1;
    end else if (i.oc == 3'b100) begin                  // STR
      e.halted = 0; e.cycles = 9; e.mem_wr = 1; e.load_addr = 1;
    end else if (i.oc == 3'b001) begin                  // B<cond>
      e.halted = 0; e.cycles = 5; e.pc_rel = ref_taken(i.cd, i.st) ? 4'd1 : 4'd0;
    end
    return e;
  endfunction

  function automatic string fmt(input stats_t s);
    return $sformatf("cyc=%0d wr=%0d nsel=%b vsel=%b memwr=%0d drd=%0d pcrel=%0d pcinc=%0d lds=%0d ladr=%0d lir=%0d halt=%0d",
                     s.cycles, s.writes, s.wr_nsel, s.wr_vsel, s.mem_wr, s.data_rd,
                     s.pc_rel, s.pc_inc, s.loads, s.load_addr, s.load_ir, s.halted);
  endfunction

  // Runs one instruction. Entry: at a negedge during IF1. Exit: at the negedge
  // of the next IF1, or of the first HALT cycle. Also probes, every cycle,
  // that wiggling all inputs mid-cycle leaves the outputs untouched.
  task automatic run_instr(input instr_t i, output stats_t s, output bit moore_ok);
    logic [20:0] snap;
    s = '0;
    moore_ok = 1'b1;
    opcode = i.oc; op = i.op; cond = i.cd; status = i.st;
    for (int c = 0; c < 40; c++) begin
      if (halted === 1'b1) begin
        s.halted = 1'b1;
        break;
      end
      s.cycles = s.cycles + 1;
      if (write) begin
        s.writes = s.writes + 1; s.wr_nsel = nsel; s.wr_vsel = vsel;
      end
      if (mem_cmd == 2'b10 && addr_sel == 1'b0) s.mem_wr = s.mem_wr + 1;
      if (mem_cmd == 2'b01 && addr_sel == 1'b0) s.data_rd = s.data_rd + 1;
      if (load_pc && pc_src == 2'b01) s.pc_rel = s.pc_rel + 1;
      if (load_pc && pc_src == 2'b00) s.pc_inc = s.pc_inc + 1;
      if (loads)     s.loads = s.loads + 1;
      if (load_addr) s.load_addr = s.load_addr + 1;
      if (load_ir)   s.load_ir = s.load_ir + 1;
      snap = ctl;
      opcode = ~i.oc; op = ~i.op; cond = ~i.cd; status = ~i.st;
      #1;
      if (ctl !== snap) moore_ok = 1'b0;
      opcode = i.oc; op = i.op; cond = i.cd; status = i.st;
      @(negedge clk);
      if (ctl === IF1_CTL) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== RST_CTL) begin
      errors++; $display("FAIL reset_async: got %b want %b", ctl, RST_CTL);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ctl !== RST_CTL) begin
      errors++; $display("FAIL reset_held: got %b want %b", ctl, RST_CTL);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== IF1_CTL) begin
      errors++; $display("FAIL reset_first_fetch: got %b want %b", ctl, IF1_CTL);
    end
  endtask

  task automatic test_sequence(input string name, input instr_t q[$]);
    stats_t obs, exp;
    bit mo;
    foreach (q[k]) begin
      run_instr(q[k], obs, mo);
      exp = model(q[k]);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s[%0d] oc=%b op=%b cd=%b st=%b: got %s want %s",
                 name, k, q[k].oc, q[k].op, q[k].cd, q[k].st, fmt(obs), fmt(exp));
      end
      checks++;
      if (!mo) begin
        errors++; $display("FAIL %s[%0d] moore: outputs followed inputs, got 1 want 0", name, k);
      end
    end
  endtask

  task automatic test_mov_imm();
    instr_t q[$];
    q.push_back(mk(3'b110, 2'b10, 3'b000, 3'b000));  // MOV R0,#5
    q.push_back(mk(3'b110, 2'b10, 3'b101, 3'b111));
    test_sequence("mov_imm", q);
  endtask

  task automatic test_branch();
    instr_t q[$];
    q.push_back(mk(3'b101, 2'b01, 3'b000, 3'b000));  // CMP
    q.push_back(mk(3'b001, 2'b00, 3'b001, 3'b001));  // BEQ, Z=1 -> taken
    q.push_back(mk(3'b101, 2'b01, 3'b000, 3'b001));  // CMP
    q.push_back(mk(3'b001, 2'b00, 3'b001, 3'b000));  // BEQ, Z=0 -> not taken
    q.push_back(mk(3'b001, 2'b00, 3'b011, 3'b010));  // BLT N=1 V=0 -> taken
    q.push_back(mk(3'b001, 2'b00, 3'b011, 3'b110));  // BLT N=1 V=1 -> not taken
    q.push_back(mk(3'b001, 2'b00, 3'b111, 3'b010));  // cond 111 -> never
    q.push_back(mk(3'b001, 2'b00, 3'b100, 3'b001));  // BLE via Z
    q.push_back(mk(3'b001, 2'b00, 3'b010, 3'b000));  // BNE taken
    test_sequence("branch", q);
  endtask

  task automatic test_mem();
    instr_t q[$];
    q.push_back(mk(3'b100, 2'b00, 3'b000, 3'b000));  // STR
    q.push_back(mk(3'b011, 2'b00, 3'b000, 3'b000));  // LDR
    q.push_back(mk(3'b100, 2'b00, 3'b000, 3'b000));  // STR back to back
    q.push_back(mk(3'b110, 2'b00, 3'b000, 3'b000));  // MOV Rd,Rm
    test_sequence("mem", q);
  endtask

  task automatic test_random();
    instr_t q[$];
    logic [2:0] oc;
    logic [1:0] o;
    for (int k = 0; k < 60; k++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 5))
        0: begin oc = 3'b110; o = 2'b10; end
        1: begin oc = 3'b110; o = 2'b00; end
        2: oc = 3'b101;
        3: oc = 3'b011;
        4: oc = 3'b100;
        default: oc = 3'b001;
      endcase
      q.push_back(mk(oc, o, 3'($urandom), 3'($urandom)));
    end
    test_sequence("random", q);
  endtask

  task automatic test_reset_mid_exec();
    int bad;
    opcode = 3'b101; op = 2'b00; cond = 3'b000; status = 3'b000;  // ADD
    repeat (6) @(negedge clk);  // now in EXEC (7th cycle of the instruction)
    checks++;
    if ({loadc, asel, write} !== 3'b100) begin
      errors++; $display("FAIL mid_exec_reached: got %b want 100", {loadc, asel, write});
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (ctl !== RST_CTL) begin
      errors++; $display("FAIL mid_exec_reset_now: got %b want %b", ctl, RST_CTL);
    end
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ctl !== RST_CTL) bad++;
      @(negedge clk);
      if (ctl !== RST_CTL) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mid_exec_reset_hold: got %0d bad samples want 0", bad);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== IF1_CTL) begin
      errors++; $display("FAIL mid_exec_refetch: got %b want %b", ctl, IF1_CTL);
    end
  endtask

  task automatic test_halt(input string name, input logic [2:0] oc, input logic [1:0] o);
    stats_t obs, exp;
    bit mo;
    int bad;
    instr_t i;
    i = mk(oc, o, 3'b000, 3'b000);
    run_instr(i, obs, mo);
    exp = model(i);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL %s_enter: got %s want %s", name, fmt(obs), fmt(exp));
    end
    bad = 0;
    repeat (20) begin
      opcode = 3'($urandom); op = 2'($urandom); cond = 3'($urandom); status = 3'($urandom);
      @(negedge clk);
      if (ctl !== HALT_CTL) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s_hold: got %0d bad cycles want 0", name, bad);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (ctl !== RST_CTL) begin
      errors++; $display("FAIL %s_reset: got %b want %b", name, ctl, RST_CTL);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== IF1_CTL) begin
      errors++; $display("FAIL %s_exit: got %b want %b", name, ctl, IF1_CTL);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_branch();
    test_mem();
    test_reset_mid_exec();
    test_random();
    test_halt("halt_111", 3'b111, 2'b00);
    test_halt("halt_000", 3'b000, 2'b11);
    test_halt("halt_mov01", 3'b110, 2'b01);
`ifndef CTRL_BRANCH_LINK_EN
    test_halt("halt_010", 3'b010, 2'b11);
`endif
    test_mov_imm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
